// File: rtl/axi_pkt_loopback_pkg.sv
// axi_pkt_loopback_pkg: mode encodings, write FSM states and setting register offsets
package axi_pkt_loopback_pkg;
    typedef enum logic [1:0] {
        CUT_THROUGH = 2'd0,
        STORE_FWD   = 2'd1,
        DROP        = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;
    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;
    localparam logic [7:0] SR_MODE = 8'd0;
    localparam logic [7:0] SR_CLR  = 8'd1;
endpackage

// File: rtl/axi_pkt_loopback_ram.sv
// axi_pkt_loopback_ram: simple dual-port storage, synchronous write, asynchronous read
module axi_pkt_loopback_ram #(
    parameter int DW = 33,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_pkt_loopback.sv
// axi_pkt_loopback: packet buffer loopback with cut-through, store-and-forward and drop modes
module axi_pkt_loopback
    import axi_pkt_loopback_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 5,
    parameter int SR_BASE = 129
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [63:0]      rb_data,
    output logic [SIZE:0]    occupied
);
    logic [SIZE:0] wr_ptr, rd_ptr, commit_ptr;
    mode_t mode, pkt_mode, pkt_mode_nxt, cur_mode;
    state_t state, state_nxt;
    logic [31:0] pkt_in_count, pkt_out_count;
    logic [WIDTH:0] rd_word;
    logic full, in_hs, out_hs, wr_en, oversize, mode_wr, cnt_clr, unused_set;

    assign unused_set = ^set_data[31:2];
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {SIZE{1'b0}}};
    assign cur_mode  = state == IDLE ? mode : pkt_mode;
    assign i_tready  = cur_mode == DROP || !full;
    assign in_hs     = i_tvalid && i_tready;
    assign wr_en     = in_hs && cur_mode != DROP;
    assign o_tvalid  = rd_ptr != commit_ptr;
    assign out_hs    = o_tvalid && o_tready;
    assign o_tdata   = o_tvalid ? rd_word[WIDTH-1:0] : '0;
    assign o_tlast   = o_tvalid && rd_word[WIDTH];
    assign occupied  = wr_ptr - rd_ptr;
    assign rb_data   = {pkt_out_count, pkt_in_count};
    assign mode_wr   = set_stb && set_addr == 8'(SR_BASE + SR_MODE);
    assign cnt_clr   = set_stb && set_addr == 8'(SR_BASE + SR_CLR);
    // a store-and-forward packet larger than the buffer would never commit; release it as cut-through
    assign oversize  = state == BODY && pkt_mode == STORE_FWD && full && commit_ptr == rd_ptr;

    axi_pkt_loopback_ram #(.DW(WIDTH + 1), .AW(SIZE)) ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[SIZE-1:0]),
        .wdata ({i_tlast, i_tdata}),
        .raddr (rd_ptr[SIZE-1:0]),
        .rdata (rd_word)
    );

    always_comb begin
        state_nxt    = state;
        pkt_mode_nxt = pkt_mode;
        if (in_hs) begin
            if (state == IDLE) pkt_mode_nxt = mode;
            state_nxt = i_tlast ? IDLE : BODY;
        end else if (oversize) pkt_mode_nxt = CUT_THROUGH;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= IDLE;
            pkt_mode   <= CUT_THROUGH;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            state    <= state_nxt;
            pkt_mode <= pkt_mode_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (out_hs) rd_ptr <= rd_ptr + 1'b1;
            if (oversize) commit_ptr <= wr_ptr;
            else if (wr_en && (cur_mode != STORE_FWD || i_tlast)) commit_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mode <= CUT_THROUGH;
        else if (mode_wr) mode <= mode_t'(set_data[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            pkt_in_count  <= '0;
            pkt_out_count <= '0;
        end else begin
            if (in_hs && i_tlast) pkt_in_count <= pkt_in_count + 1'b1;
            if (out_hs && o_tlast) pkt_out_count <= pkt_out_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_pkt_loopback.sv
// tb_axi_pkt_loopback: directed stimulus with a scoreboard queue checked by an output monitor
module tb_axi_pkt_loopback;
    logic        clk = 0, reset = 1, clear = 0, set_stb = 0;
    logic [7:0]  set_addr = 0;
    logic [31:0] set_data = 0;
    logic [31:0] i_tdata = 0;
    logic        i_tlast = 0, i_tvalid = 0, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready = 0;
    logic [63:0] rb_data;
    logic [5:0]  occupied;
    logic [32:0] sb[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    axi_pkt_loopback dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .rb_data(rb_data), .occupied(occupied)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_unexpected: got %0h expected no beat", {o_tlast, o_tdata});
            end else check("out_beat", 64'({o_tlast, o_tdata}), 64'(sb.pop_front()));
        end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1; set_addr = a; set_data = d;
        tick();
        set_stb = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input bit keep);
        int t = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1;
        @(negedge clk);
        while (!i_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!i_tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got i_tready=0 expected 1 for beat %0h", d);
        end else if (keep) sb.push_back({l, d});
        tick();
        i_tvalid = 0; i_tlast = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || o_tvalid) && t < 500) begin
            tick();
            t++;
        end
        check("drain", 64'(sb.size()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 0;
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_occupied", occupied, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_i_tready", i_tready, 1);
        // cut-through: first beat visible the cycle after acceptance
        o_tready = 1;
        send(1, 0, 1);
        check("ct_latency", o_tvalid, 1);
        send(2, 0, 1);
        send(3, 0, 1);
        send(4, 1, 1);
        wait_drain();
        check("ct_counts", rb_data, {32'd1, 32'd1});
        // store-and-forward with gaps
        sr_write(8'd129, 1);
        for (int i = 0; i < 5; i++) begin
            send(10 + i, i == 4, 1);
            if (i < 4) begin
                check("sf_hold", o_tvalid, 0);
                tick(2);
            end
        end
        check("sf_latency", o_tvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sf_contig", o_tvalid, 1);
        end
        wait_drain();
        // fill to capacity in cut-through with output stalled
        sr_write(8'd129, 0);
        o_tready = 0;
        for (int i = 0; i < 32; i++) send(100 + i, 0, 1);
        check("full_i_tready", i_tready, 0);
        check("full_occupied", occupied, 32);
        o_tready = 1;
        for (int i = 32; i < 40; i++) send(100 + i, i == 39, 1);
        wait_drain();
        // oversize store-and-forward packet
        sr_write(8'd129, 1);
        o_tready = 0;
        for (int i = 0; i < 32; i++) send(200 + i, 0, 1);
        check("ovs_hold", o_tvalid, 0);
        tick();
        check("ovs_release", o_tvalid, 1);
        o_tready = 1;
        for (int i = 32; i < 40; i++) send(200 + i, i == 39, 1);
        wait_drain();
        check("ovs_counts", rb_data, {32'd4, 32'd4});
        // mode change to DROP mid-packet
        sr_write(8'd130, 0);
        check("cnt_clear", rb_data, 0);
        sr_write(8'd129, 0);
        send(300, 0, 1);
        sr_write(8'd129, 2);
        send(301, 0, 1);
        send(302, 1, 1);
        send(400, 0, 0);
        send(401, 1, 0);
        tick(3);
        wait_drain();
        check("drop_counts", rb_data, {32'd1, 32'd2});
        check("drop_occupied", occupied, 0);
        // clear with stored beats
        sr_write(8'd129, 0);
        o_tready = 0;
        send(500, 0, 1);
        send(501, 0, 1);
        send(502, 0, 1);
        check("pre_clear_occ", occupied, 3);
        clear = 1;
        tick();
        clear = 0;
        sb.delete();
        check("clr_o_tvalid", o_tvalid, 0);
        check("clr_occupied", occupied, 0);
        check("clr_counts", rb_data, {32'd1, 32'd2});
        o_tready = 1;
        send(600, 1, 1);
        wait_drain();
        check("post_clear_counts", rb_data, {32'd2, 32'd3});
        // reset mid-packet
        o_tready = 0;
        send(700, 0, 1);
        reset = 1;
        tick();
        reset = 0;
        sb.delete();
        check("mid_rst_occ", occupied, 0);
        check("mid_rst_counts", rb_data, 0);
        o_tready = 1;
        send(701, 1, 1);
        wait_drain();
        check("post_rst_counts", rb_data, {32'd1, 32'd1});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
